// File: rtl/ndc_map_scheduler.sv
// ndc_map_scheduler: round-robin front end for a shared, fixed-latency
// vertex_ndc_map pipeline. Requester IDs ride alongside in an in-order tag
// FIFO. A credit counter reserves a result slot for every issued point.
// Canvas-dimension changes wait until the pipeline has drained.
// Optional build macro NDC_SCHED_PERF_EN adds three 32-bit perf counters.
module ndc_map_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int PIPE_LATENCY = 23,
  parameter int OUT_DEPTH    = 32,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][31:0] req_pt,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [31:0]              dims_in,
  input  logic                     dims_update,
  output logic                     dims_busy,
  output logic [31:0]              map_pt,
  output logic [31:0]              map_dims,
  output logic                     map_valid,
  input  logic [31:0]              ndc_pt,
  input  logic                     ndc_pt_valid,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_pt,
  output logic [ID_W-1:0]          resp_id,
`ifdef NDC_SCHED_PERF_EN
  output logic [31:0]              perf_issued,
  output logic [31:0]              perf_stall_credit,
  output logic [31:0]              perf_stall_drain,
`endif
  output logic                     tag_error
);
  localparam int TAG_DEPTH = PIPE_LATENCY + 1;
  localparam int TAG_AW    = $clog2(TAG_DEPTH);
  localparam int TAG_CW    = $clog2(TAG_DEPTH + 1);
  localparam int OUT_AW    = $clog2(OUT_DEPTH);
  localparam int CRD_W     = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     pt;
  } res_t;

  state_t            state, state_nxt;
  logic              arb_en, load_now, active;
  logic [ID_W-1:0]   last_grant, gnt_idx, cand;
  logic              found, issue;
  logic [CRD_W-1:0]  credits;
  logic [31:0]       pending_dims;

  logic [ID_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] tag_wr, tag_rd;
  logic [TAG_CW-1:0] tag_cnt;
  logic              tag_empty, tag_pop;

  res_t              res_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] res_wr, res_rd;
  logic [CRD_W-1:0]  res_cnt;
  logic              res_full, res_pop, res_wr_en;

  assign tag_empty = (tag_cnt == '0);
  assign tag_pop   = ndc_pt_valid & ~tag_empty;
  assign res_full  = (res_cnt == CRD_W'(OUT_DEPTH));
  assign resp_valid = (res_cnt != '0);
  assign res_pop   = resp_valid & resp_ready;
  // a full FIFO still accepts a result when the head leaves the same cycle
  assign res_wr_en = tag_pop & (~res_full | res_pop);
  assign resp_pt   = resp_valid ? res_mem[res_rd].pt : '0;
  assign resp_id   = resp_valid ? res_mem[res_rd].id : '0;

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else      state <= state_nxt;

  // next-state: strobe starts a drain, empty tag FIFO allows the load
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (dims_update) state_nxt = DRAIN;
      DRAIN:   if (tag_empty)   state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // state-decoded controls
  always_comb begin
    arb_en   = (state == RUN);
    load_now = (state == LOAD);
  end

  // keeps grants off during the cycle reset is released
  always_ff @(posedge clk or negedge rst)
    if (!rst) active <= 1'b0;
    else      active <= 1'b1;

  // round-robin search starting just past the last winner
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign issue     = found & active & arb_en & (credits != '0);
  assign req_ready = issue ? (NUM_REQ'(1) << gnt_idx) : '0;

  // issue registers, grant pointer and credits
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      map_valid  <= 1'b0;
      map_pt     <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      credits    <= CRD_W'(OUT_DEPTH);
    end else begin
      map_valid <= issue;
      if (issue) begin
        map_pt     <= req_pt[gnt_idx];
        last_grant <= gnt_idx;
      end
      case ({issue, res_pop})
        2'b10:   credits <= credits - CRD_W'(1);
        2'b01:   credits <= credits + CRD_W'(1);
        default: credits <= credits;
      endcase
    end

  // dimension staging; a strobe during LOAD still wins
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pending_dims <= '0;
      map_dims     <= '0;
      dims_busy    <= 1'b0;
    end else begin
      if (dims_update) pending_dims <= dims_in;
      if (load_now) begin
        map_dims  <= dims_update ? dims_in : pending_dims;
        dims_busy <= 1'b0;
      end else if (arb_en && dims_update) begin
        dims_busy <= 1'b1;
      end
    end

  // tag FIFO storage
  always_ff @(posedge clk)
    if (issue) tag_mem[tag_wr] <= gnt_idx;

  // tag FIFO pointers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
    end else begin
      if (issue)   tag_wr <= (tag_wr == TAG_AW'(TAG_DEPTH - 1)) ? '0 : tag_wr + TAG_AW'(1);
      if (tag_pop) tag_rd <= (tag_rd == TAG_AW'(TAG_DEPTH - 1)) ? '0 : tag_rd + TAG_AW'(1);
      case ({issue, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + TAG_CW'(1);
        2'b01:   tag_cnt <= tag_cnt - TAG_CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end

  // result FIFO storage
  always_ff @(posedge clk)
    if (res_wr_en) res_mem[res_wr] <= '{id: tag_mem[tag_rd], pt: ndc_pt};

  // result FIFO pointers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      res_wr  <= '0;
      res_rd  <= '0;
      res_cnt <= '0;
    end else begin
      if (res_wr_en) res_wr <= (res_wr == OUT_AW'(OUT_DEPTH - 1)) ? '0 : res_wr + OUT_AW'(1);
      if (res_pop)   res_rd <= (res_rd == OUT_AW'(OUT_DEPTH - 1)) ? '0 : res_rd + OUT_AW'(1);
      case ({res_wr_en, res_pop})
        2'b10:   res_cnt <= res_cnt + CRD_W'(1);
        2'b01:   res_cnt <= res_cnt - CRD_W'(1);
        default: res_cnt <= res_cnt;
      endcase
    end

  // sticky error: orphan result or result with nowhere to go
  always_ff @(posedge clk or negedge rst)
    if (!rst) tag_error <= 1'b0;
    else if (ndc_pt_valid && (tag_empty || (res_full && !res_pop))) tag_error <= 1'b1;

`ifdef NDC_SCHED_PERF_EN
  // performance counters, free-running wrap
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      perf_issued       <= '0;
      perf_stall_credit <= '0;
      perf_stall_drain  <= '0;
    end else begin
      if (issue) perf_issued <= perf_issued + 32'd1;
      if (|req_valid && credits == '0) perf_stall_credit <= perf_stall_credit + 32'd1;
      if (|req_valid && !arb_en) perf_stall_drain <= perf_stall_drain + 32'd1;
    end
`endif
endmodule
